// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sw_pkg
// Brief    : Shared switch-bank constants, also used by the processor I/O map.
// Revision : 1.0
// ============================================================================
package sw_pkg;

    localparam int unsigned c_NUM_SW_DEFAULT          = 17;
    localparam int unsigned c_DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int unsigned c_RAW_W                   = 32;

    typedef logic [c_RAW_W-1:0] raw_pins_t;

    // Counter must hold values up to DEBOUNCE_CYCLES-1 without wrapping.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage : sw_pkg
`default_nettype wire

// File: rtl/sw_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce_bit
// Brief    : One switch bit: 2-flop synchronizer, debounce counter, level and
//            sticky change-event flop.
// Revision : 1.0
// ============================================================================
module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_clr,
    output logic o_level,
    output logic o_evt,
    output logic o_evt_nxt
);

    localparam int unsigned      CNT_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_evt;

    logic w_differ;
    logic w_accept;
    logic w_evt_nxt;

    assign w_differ  = r_s2 ^ r_level;
    assign w_accept  = w_differ && (r_cnt == c_TERM);
    // A new accepted change beats a simultaneous clear.
    assign w_evt_nxt = w_accept | (r_evt & ~i_clr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_s1  <= i_raw;
            r_s2  <= r_s1;
            r_evt <= w_evt_nxt;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_level <= r_s2;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    assign o_level   = r_level;
    assign o_evt     = r_evt;
    assign o_evt_nxt = w_evt_nxt;

endmodule : sw_debounce_bit
`default_nettype wire

// File: rtl/sw_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sw_input_conditioner
// Brief    : Synchronizes, debounces and flags changes on the switch bank;
//            drives a registered interrupt from enabled sticky events.
// Revision : 1.0
// ============================================================================
module sw_input_conditioner
    import sw_pkg::*;
#(
    parameter int unsigned NUM_SW          = c_NUM_SW_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [c_RAW_W-1:0] io_sw_i,
    input  logic [NUM_SW-1:0]  evt_en_i,
    input  logic [NUM_SW-1:0]  evt_clr_i,
    output logic [NUM_SW-1:0]  sw_o,
    output logic [NUM_SW-1:0]  evt_o,
    output logic               irq_o
);

    logic [NUM_SW-1:0] w_evt_nxt;
    logic              r_irq;

    generate
        for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
            sw_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_bit (
                .i_clk    (clk_i),
                .i_rst_n  (rst_ni),
                .i_raw    (io_sw_i[i]),
                .i_clr    (evt_clr_i[i]),
                .o_level  (sw_o[i]),
                .o_evt    (evt_o[i]),
                .o_evt_nxt(w_evt_nxt[i])
            );
        end

        // Pins above the conditioned range are deliberately ignored.
        if (NUM_SW < c_RAW_W) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^io_sw_i[c_RAW_W-1:NUM_SW];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_evt_nxt & evt_en_i);
        end
    end

    assign irq_o = r_irq;

endmodule : sw_input_conditioner
`default_nettype wire
